bcd_seq_converter: RTL and testbench
====================================

# bcd_seq_converter

- Iterative, parametrised binary-to-BCD converter (shift-add-3 / double-dabble).
- Processes one input bit per clock and generalises the cube's fixed 6-bit combinational converter to arbitrary input width and digit count.
- Adds a valid/ready handshake on both sides, saturation with an overflow flag, and a leading-zero blanking mask.
- Sits between the pattern/score counters and the display/text-rendering logic of the LED cube controller.

## Interface
Parameters:
- IN_WIDTH, default 16: binary input width; legal range ≥ 1.
- DIGITS, default 5: number of BCD output digits; legal range ≥ 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_bin is valid.
- in_ready  output  1  converter can accept a new value.
- in_bin  input  IN_WIDTH  unsigned binary value.
- out_valid  output  1  result is valid and held stable.
- out_ready  input  1  consumer accepts the result.
- out_bcd  output  4*DIGITS  packed BCD result; digit i occupies bits [4i+3:4i], digit 0 is the least significant.
- out_lz_mask  output  DIGITS  bit i = 1 when digit i is a leading zero (this digit and all higher digits are 0). Bit 0 is always 0.
- overflow  output  1  in_bin ≥ 10^DIGITS; qualified by out_valid.

## Operation
States:
- **IDLE**: in_ready = 1.
  - On in_valid: load the shift register with in_bin, clear the BCD accumulator and the overflow flag, set bit counter = IN_WIDTH − 1, go to SHIFT.
- **SHIFT**: in_ready = 0. Each cycle performs one iteration:
  - Every digit ≥ 5 gets +3 (4-bit result; no carry between digits).
  - Then shift {accumulator, shift register} left by one.
  - If the bit shifted out of the top of the accumulator is 1, set the sticky overflow flag.
  - When counter == 0, go to DONE; otherwise decrement the counter.
- **DONE**: out_valid = 1.
  - out_bcd, out_lz_mask and overflow are held stable.
  - On out_ready, go to IDLE.

Output rules:
- When overflow = 1, out_bcd = all digits 9 (saturated) and out_lz_mask = 0.
- out_bcd and out_lz_mask are registered values. They are updated only on the SHIFT→DONE edge and are never combinationally dependent on in_bin.
- in_valid while in SHIFT or DONE is ignored; the upstream side must hold its value until in_ready.
- Reset mid-conversion aborts the conversion immediately. No partial result is ever presented.

Reset values:
- state = IDLE, in_ready = 1, out_valid = 0, out_bcd = 0, out_lz_mask = 0, overflow = 0.
- Counter and shift register are cleared.

## Timing
- Accept edge: the rising edge where in_valid && in_ready.
- Shift iterations occur on the next IN_WIDTH edges. out_valid rises after the IN_WIDTH-th of these edges, i.e. IN_WIDTH cycles after the accept edge.
- Throughput: one result every IN_WIDTH + 2 cycles when out_ready is tied high. This covers the accept edge, IN_WIDTH shift edges, and the DONE→IDLE edge.
- in_ready returns to 1 the cycle after the out_ready handshake. There is no same-cycle accept while in DONE.
- IN_WIDTH = 1: a single SHIFT cycle; the result is 0 or 1.
- Counter width: $clog2(IN_WIDTH), minimum 1 bit.

## Structure
- Shared package bcd_pkg contains:
  - state enum {IDLE, SHIFT, DONE};
  - constant BCD_DIGIT_W = 4;
  - constant BCD_ADJ_THRESH = 5;
  - constant BCD_ADJ_ADD = 3.
- Sub-module bcd_digit_adj: combinational, one 4-bit digit in, adjusted digit out (+3 if ≥ 5). Instantiated DIGITS times in a generate loop.
- Top level contains the FSM, counter, shift/accumulator register, overflow flag, saturation and leading-zero mask logic.

## Test plan
1. IN_WIDTH=16, DIGITS=5, in_bin = 0:
   - out_bcd = 0x00000, out_lz_mask = 5'b11110, overflow = 0;
   - out_valid exactly 16 cycles after the accept edge.
2. in_bin = 65535:
   - out_bcd = 0x65535, out_lz_mask = 0, overflow = 0.
   - Then in_bin = 407: out_bcd = 0x00407, mask = 5'b11000.
3. DIGITS=4, in_bin = 12345:
   - overflow = 1, out_bcd = 0x9999, mask = 0.
   - Next in_bin = 9999: overflow = 0, out_bcd = 0x9999.
4. Backpressure: out_ready held low for 10 cycles in DONE.
   - out_valid and out_bcd stay stable, in_ready stays 0.
   - in_valid pulses during SHIFT/DONE are ignored.
   - After out_ready, the next value is accepted the following cycle.
5. Assert rst during the 8th SHIFT cycle:
   - Asynchronously in_ready = 1, out_valid = 0, out_bcd = 0.
   - A fresh conversion of 42 after reset yields 0x00042.
6. Randomised sweep, IN_WIDTH=10, DIGITS=3, out_ready tied high:
   - All 1024 inputs checked against a decimal model; overflow exactly for inputs ≥ 1000.
   - Back-to-back throughput = 12 cycles per result.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  localparam int         BCD_DIGIT_W    = 4;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_in,
  output logic [BCD_DIGIT_W-1:0] digit_out
);

  always_comb begin
    digit_out = digit_in;
    if (digit_in >= BCD_ADJ_THRESH) begin
      digit_out = digit_in + BCD_ADJ_ADD;
    end
  end

endmodule

// File: rtl/bcd_seq_converter.sv
// Iterative binary-to-BCD converter, one input bit per clock, with valid/ready
// handshakes, saturation on overflow and a leading-zero blanking mask.
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int IN_WIDTH = 16,
  parameter int DIGITS   = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [IN_WIDTH-1:0]         in_bin,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
  output logic [DIGITS-1:0]           out_lz_mask,
  output logic                        overflow
);

  localparam int CNT_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam int ACC_W = BCD_DIGIT_W * DIGITS;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IN_WIDTH-1:0] shift_q, shift_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [ACC_W-1:0]    out_bcd_q, out_bcd_d;
  logic [DIGITS-1:0]   out_lz_q, out_lz_d;
  logic                overflow_q, overflow_d;

  logic [ACC_W-1:0]    acc_adj;
  logic [ACC_W-1:0]    acc_next;
  logic [IN_WIDTH-1:0] shift_next;
  logic                ovf_next;
  logic [DIGITS-1:0]   lz_mask;
  logic                zero_above;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in (acc_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_out(acc_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // A 1 falling off the top digit means the value no longer fits in DIGITS.
  always_comb begin
    acc_next   = {acc_adj[ACC_W-2:0], shift_q[IN_WIDTH-1]};
    shift_next = shift_q << 1;
    ovf_next   = ovf_q | acc_adj[ACC_W-1];
  end

  always_comb begin
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (acc_next[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0);
      lz_mask[i] = zero_above;
    end
    if (ovf_next) begin
      lz_mask = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_bcd_d   = out_bcd_q;
    out_lz_d    = out_lz_q;
    overflow_d  = overflow_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d    = in_bin;
          acc_d      = '0;
          ovf_d      = 1'b0;
          cnt_d      = CNT_W'(IN_WIDTH - 1);
          in_ready_d = 1'b0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        acc_d   = acc_next;
        shift_d = shift_next;
        ovf_d   = ovf_next;
        if (cnt_q == '0) begin
          out_valid_d = 1'b1;
          out_bcd_d   = ovf_next ? {DIGITS{4'h9}} : acc_next;
          out_lz_d    = lz_mask;
          overflow_d  = ovf_next;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_bcd_q   <= '0;
      out_lz_q    <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_bcd_q   <= out_bcd_d;
      out_lz_q    <= out_lz_d;
      overflow_q  <= overflow_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_bcd     = out_bcd_q;
  assign out_lz_mask = out_lz_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Self-checking bench for bcd_seq_converter: three parameterisations checked
// against a decimal reference model.
module tb_bcd_seq_converter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cycleCount = 0;
  int   compareCount = 0;
  int   mismatchCount = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Instance A: 16 bits, 5 digits
  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_overflow;
  logic [15:0] a_in_bin = '0;
  logic [19:0] a_out_bcd;
  logic [4:0]  a_out_lz_mask;

  // Instance B: 16 bits, 4 digits
  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_overflow;
  logic [15:0] b_in_bin = '0;
  logic [15:0] b_out_bcd;
  logic [3:0]  b_out_lz_mask;

  // Instance C: 10 bits, 3 digits, consumer always ready
  logic        c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b1, c_overflow;
  logic [9:0]  c_in_bin = '0;
  logic [11:0] c_out_bcd;
  logic [2:0]  c_out_lz_mask;

  bcd_seq_converter #(.IN_WIDTH(16), .DIGITS(5)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_bin(a_in_bin),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_bcd(a_out_bcd),
    .out_lz_mask(a_out_lz_mask), .overflow(a_overflow));

  bcd_seq_converter #(.IN_WIDTH(16), .DIGITS(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_bin(b_in_bin),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_bcd(b_out_bcd),
    .out_lz_mask(b_out_lz_mask), .overflow(b_overflow));

  bcd_seq_converter #(.IN_WIDTH(10), .DIGITS(3)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_bin(c_in_bin),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_bcd(c_out_bcd),
    .out_lz_mask(c_out_lz_mask), .overflow(c_overflow));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Decimal reference: digits by repeated division, significance by digit count.
  function automatic void bcdModel(input longint unsigned v, input int digits,
                                   output logic [31:0] bcd, output logic [7:0] mask,
                                   output logic ovf);
    longint unsigned limit = 1;
    longint unsigned t;
    int nsig = 1;
    for (int i = 0; i < digits; i++) limit = limit * 10;
    bcd  = '0;
    mask = '0;
    ovf  = (v >= limit);
    if (ovf) begin
      for (int i = 0; i < digits; i++) bcd[4*i +: 4] = 4'd9;
    end else begin
      t = v;
      for (int i = 0; i < digits; i++) begin
        bcd[4*i +: 4] = 4'(t % 10);
        t = t / 10;
      end
      t = v;
      while (t >= 10) begin
        t = t / 10;
        nsig++;
      end
      for (int i = 0; i < digits; i++) mask[i] = (i >= nsig);
    end
  endfunction

  task automatic applyStimulus(input logic [15:0] value, output logic [19:0] bcd,
                               output logic [4:0] mask, output logic ovf, output int lat);
    int n = 0;
    while (!a_in_ready && n < 100) begin
      tick();
      n++;
    end
    checkOutput("a_ready_before_accept", 64'(a_in_ready), 64'd1);
    a_in_bin   = value;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    lat = 0;
    while (!a_out_valid && lat < 100) begin
      tick();
      lat++;
    end
    bcd  = a_out_bcd;
    mask = a_out_lz_mask;
    ovf  = a_overflow;
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
  endtask

  task automatic convertCheckA(input string tag, input logic [15:0] value);
    logic [19:0] bcd;
    logic [4:0]  mask;
    logic        ovf;
    int          lat;
    logic [31:0] eBcd;
    logic [7:0]  eMask;
    logic        eOvf;
    applyStimulus(value, bcd, mask, ovf, lat);
    bcdModel(longint'(value), 5, eBcd, eMask, eOvf);
    checkOutput({tag, "_bcd"}, 64'(bcd), 64'(eBcd));
    checkOutput({tag, "_mask"}, 64'(mask), 64'(eMask));
    checkOutput({tag, "_ovf"}, 64'(ovf), 64'(eOvf));
    checkOutput({tag, "_latency"}, 64'(lat), 64'd16);
  endtask

  task automatic convertCheckB(input string tag, input logic [15:0] value);
    int          n = 0;
    int          lat = 0;
    logic [31:0] eBcd;
    logic [7:0]  eMask;
    logic        eOvf;
    while (!b_in_ready && n < 100) begin
      tick();
      n++;
    end
    b_in_bin   = value;
    b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    while (!b_out_valid && lat < 100) begin
      tick();
      lat++;
    end
    bcdModel(longint'(value), 4, eBcd, eMask, eOvf);
    checkOutput({tag, "_bcd"}, 64'(b_out_bcd), 64'(eBcd));
    checkOutput({tag, "_mask"}, 64'(b_out_lz_mask), 64'(eMask));
    checkOutput({tag, "_ovf"}, 64'(b_overflow), 64'(eOvf));
    checkOutput({tag, "_latency"}, 64'(lat), 64'd16);
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] eBcd;
    logic [7:0]  eMask;
    logic        eOvf;
    logic [15:0] bpVal;
    logic [15:0] nextVal;
    int          lat;
    int          prevCycle;
    int          vals[1024];

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    checkOutput("reset_in_ready", 64'(a_in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(a_out_valid), 64'd0);
    checkOutput("reset_out_bcd", 64'(a_out_bcd), 64'd0);
    checkOutput("reset_lz_mask", 64'(a_out_lz_mask), 64'd0);
    checkOutput("reset_overflow", 64'(a_overflow), 64'd0);

    convertCheckA("zero", 16'd0);
    convertCheckA("max16", 16'd65535);
    convertCheckA("v407", 16'd407);
    for (int i = 0; i < 20; i++) convertCheckA("rand_a", 16'($urandom));

    convertCheckB("ovf12345", 16'd12345);
    convertCheckB("v9999", 16'd9999);
    convertCheckB("v10000", 16'd10000);

    // Backpressure with spurious in_valid pulses during SHIFT and DONE
    bpVal      = 16'($urandom);
    a_in_bin   = bpVal;
    a_in_valid = 1'b1;
    tick();
    lat = 0;
    while (!a_out_valid && lat < 100) begin
      a_in_valid = lat[0];
      a_in_bin   = 16'($urandom);
      tick();
      lat++;
    end
    checkOutput("bp_latency", 64'(lat), 64'd16);
    bcdModel(longint'(bpVal), 5, eBcd, eMask, eOvf);
    for (int k = 0; k < 10; k++) begin
      a_in_valid = k[0];
      tick();
      checkOutput("bp_out_valid", 64'(a_out_valid), 64'd1);
      checkOutput("bp_out_bcd", 64'(a_out_bcd), 64'(eBcd));
      checkOutput("bp_in_ready", 64'(a_in_ready), 64'd0);
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    checkOutput("bp_release_in_ready", 64'(a_in_ready), 64'd1);
    checkOutput("bp_release_out_valid", 64'(a_out_valid), 64'd0);
    nextVal    = 16'd31415;
    a_in_bin   = nextVal;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    checkOutput("bp_next_accepted", 64'(a_in_ready), 64'd0);
    lat = 0;
    while (!a_out_valid && lat < 100) begin
      tick();
      lat++;
    end
    bcdModel(longint'(nextVal), 5, eBcd, eMask, eOvf);
    checkOutput("bp_next_bcd", 64'(a_out_bcd), 64'(eBcd));
    checkOutput("bp_next_latency", 64'(lat), 64'd16);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;

    // Reset asserted during the 8th SHIFT cycle
    a_in_bin   = 16'd54321;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    repeat (7) tick();
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_in_ready", 64'(a_in_ready), 64'd1);
    checkOutput("abort_out_valid", 64'(a_out_valid), 64'd0);
    checkOutput("abort_out_bcd", 64'(a_out_bcd), 64'd0);
    #2 rst = 1'b0;
    tick();
    checkOutput("abort_idle_valid", 64'(a_out_valid), 64'd0);
    convertCheckA("after_abort_42", 16'd42);

    // Full 10-bit sweep in random order, back to back
    for (int i = 0; i < 1024; i++) vals[i] = i;
    for (int i = 1023; i > 0; i--) begin
      int j;
      int tmp;
      j       = int'($urandom_range(i, 0));
      tmp     = vals[i];
      vals[i] = vals[j];
      vals[j] = tmp;
    end
    prevCycle = 0;
    for (int i = 0; i < 1024; i++) begin
      int n = 0;
      while (!c_in_ready && n < 50) begin
        tick();
        n++;
      end
      c_in_bin   = 10'(vals[i]);
      c_in_valid = 1'b1;
      tick();
      lat = 0;
      while (!c_out_valid && lat < 50) begin
        tick();
        lat++;
      end
      bcdModel(longint'(vals[i]), 3, eBcd, eMask, eOvf);
      checkOutput("sweep_result",
                  {23'b0, c_overflow, 5'b0, c_out_lz_mask, 20'b0, c_out_bcd},
                  {23'b0, eOvf, eMask, eBcd});
      if (i > 0) checkOutput("sweep_throughput", 64'(cycleCount - prevCycle), 64'd12);
      prevCycle = cycleCount;
      tick();
    end
    c_in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
